// File: rtl/busy_timer.sv
// Programmable busy/hold-off timer with one-shot, retrigger and periodic modes plus abort.
// Define BUSY_TIMER_PRESCALE_EN to add the i_prescale port and a tick prescaler.
module busy_timer #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned DEFAULT_AMOUNT = 22,
    parameter int unsigned PRESCALE_W     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_amount,
    input  logic [1:0]            i_mode,
    input  logic                  i_abort,
`ifdef BUSY_TIMER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] i_prescale,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_start_ack,
    output logic [WIDTH-1:0]      o_count
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_RETRIG   = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_ONESHOT3 = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (DEFAULT_AMOUNT < 1 || PRESCALE_W < 1 || (64'(DEFAULT_AMOUNT) >> WIDTH) != 0) begin : g_param_check
        $error("busy_timer: DEFAULT_AMOUNT must be in 1..2^WIDTH-1 and PRESCALE_W >= 1");
    end

    state_t           state, state_next;
    mode_t            mode_lat, mode_next;
    logic [WIDTH-1:0] amount_lat, amount_next;
    logic [WIDTH-1:0] count, count_next;
    logic             done_next, ack_next;
    logic [WIDTH-1:0] amount_eff;
    logic             accept;
    logic             tick;

`ifdef BUSY_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc, presc_next;
    logic [PRESCALE_W-1:0] presc_lat, presc_lat_next;

    assign tick = (presc == presc_lat);
`else
    assign tick = 1'b1;
`endif

    assign amount_eff = (i_amount == '0) ? WIDTH'(DEFAULT_AMOUNT) : i_amount;
    // A retrigger-mode run keeps accepting starts; other modes only accept from idle.
    assign accept     = i_start && ((state == IDLE) || (mode_lat == MODE_RETRIG));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            mode_lat    <= MODE_ONESHOT;
            amount_lat  <= '0;
            count       <= '0;
            o_done      <= 1'b0;
            o_start_ack <= 1'b0;
`ifdef BUSY_TIMER_PRESCALE_EN
            presc       <= '0;
            presc_lat   <= '0;
`endif
        end else begin
            state       <= state_next;
            mode_lat    <= mode_next;
            amount_lat  <= amount_next;
            count       <= count_next;
            o_done      <= done_next;
            o_start_ack <= ack_next;
`ifdef BUSY_TIMER_PRESCALE_EN
            presc       <= presc_next;
            presc_lat   <= presc_lat_next;
`endif
        end
    end

    always_comb begin
        state_next     = state;
        mode_next      = mode_lat;
        amount_next    = amount_lat;
        count_next     = count;
        done_next      = 1'b0;
        ack_next       = 1'b0;
`ifdef BUSY_TIMER_PRESCALE_EN
        presc_next     = presc;
        presc_lat_next = presc_lat;
`endif

        if (i_abort) begin
            state_next = IDLE;
            count_next = '0;
`ifdef BUSY_TIMER_PRESCALE_EN
            presc_next = '0;
`endif
        end else if (accept) begin
            state_next  = RUN;
            mode_next   = mode_t'(i_mode);
            amount_next = amount_eff;
            count_next  = amount_eff - ONE;
            ack_next    = 1'b1;
`ifdef BUSY_TIMER_PRESCALE_EN
            presc_next     = '0;
            presc_lat_next = i_prescale;
`endif
        end else if (state == RUN) begin
`ifdef BUSY_TIMER_PRESCALE_EN
            presc_next = tick ? '0 : presc + 1'b1;
`endif
            if (tick) begin
                if (count != '0) begin
                    count_next = count - ONE;
                end else if (mode_lat == MODE_PERIODIC) begin
                    count_next = amount_lat - ONE;
                    done_next  = 1'b1;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
        end
    end

    assign o_busy  = (state == RUN);
    assign o_count = count;

endmodule

// File: doc/busy_timer.md
# busy_timer

Parametrised, runtime-programmable busy timer that replaces the fixed-length single-shot counter used for start/busy handshakes. A requester pulses or holds `i_start`. The block then asserts `o_busy` for a programmed number of ticks and signals natural completion with a one-cycle `o_done` pulse. It adds one-shot, retrigger and periodic modes, abort, and an optional clock prescaler. It sits between control FSMs and any resource that needs a guaranteed hold-off or timeout window.

## Interface
- `WIDTH`, 16, width of the amount and count registers
- `DEFAULT_AMOUNT`, 22, amount used when `i_amount == 0`; must be ≥1 and < 2^WIDTH
- `PRESCALE_W`, 8, prescaler width (used only with the macro)

Ports:
- `i_clk`  in  1  sole clock; all logic on its rising edge
- `i_reset_n`  in  1  asynchronous, active-low reset
- `i_start`  in  1  start request, sampled every cycle
- `i_amount`  in  WIDTH  run length A in ticks; 0 selects `DEFAULT_AMOUNT`
- `i_mode`  in  2  00 one-shot, 01 retrigger, 10 periodic, 11 treated as one-shot
- `i_abort`  in  1  cancel the current run
- `i_prescale`  in  PRESCALE_W  tick divider P; present only with `BUSY_TIMER_PRESCALE_EN`
- `o_busy`  out  1  high while a run is active
- `o_done`  out  1  one-cycle pulse on natural completion of each period
- `o_start_ack`  out  1  one-cycle pulse, cycle after a start is accepted
- `o_count`  out  WIDTH  remaining-tick register (A-1 down to 0)

## Operation
- Reset (async assert, sync release): `o_count=0`, `o_busy=0`, `o_done=0`, `o_start_ack=0`; latched mode/amount/prescale cleared.
- Acceptance: `i_start` is accepted when `o_busy==0`. In latched retrigger mode it is also accepted while busy. In one-shot and periodic modes it is ignored while busy.
- On acceptance, latch A (after 0→`DEFAULT_AMOUNT` substitution), `i_mode` and P. Next cycle: `o_count=A-1`, `o_busy=1`, `o_start_ack=1`, prescaler cleared.
- Tick: every cycle without the macro. With the macro, a tick occurs when the prescaler equals latched P; the prescaler then wraps to 0.
- Each tick while busy: if `o_count!=0`, decrement by 1; if `o_count==0`, the period ends.
- Period end, one-shot/retrigger: `o_busy←0`, `o_done←1` for that single cycle.
- Period end, periodic: `o_count←A-1`, `o_busy` stays 1, `o_done←1` for one cycle. The block runs until abort.
- Retrigger while busy: `o_count←A_new-1`. Busy stays high, no `o_done`, `o_start_ack` pulses.
- Abort (while busy or idle): next cycle `o_count=0`, `o_busy=0`, no `o_done`, prescaler cleared.
- Priority: reset > abort > start acceptance > tick. Abort together with start drops the start.
- A=1: busy for exactly one tick; `o_count` loads 0.
- Arithmetic: unsigned, WIDTH bits. `o_count` never wraps below 0.
- Invariants: `o_count < A` whenever busy. `o_done` and `o_start_ack` are never high two consecutive cycles from the same event.

## Timing
- Start accepted in cycle N (no prescale): `o_busy` high in cycles N+1..N+A; `o_done` high in N+A+1, with `o_busy=0` in one-shot.
- With prescale P: busy spans A·(P+1) cycles; `o_done` at N+A·(P+1)+1.
- Periodic: `o_done` at N+k·A·(P+1)+1 for k=1,2,…; `o_busy` continuously high.
- `i_start` held high in one-shot: `o_busy` is low for exactly one cycle (the `o_done` cycle), and the start is re-accepted in that cycle.
- Outputs are all registered, with no combinational input→output paths.
- Reset asserted mid-run clears every output immediately, without waiting for a clock.

## Configuration
- `BUSY_TIMER_PRESCALE_EN` defined: `i_prescale` port and a PRESCALE_W-bit prescaler exist, and ticks occur every P+1 cycles.
- Not defined: the port and the prescaler are removed, every cycle is a tick, and behaviour is identical to P=0.

## Test plan
- Reset, then start with A=5, mode 00 at cycle 10 -> `o_start_ack` at 11; busy 11..15; `o_count` 4,3,2,1,0; `o_done` at 16 only.
- `i_amount=0`, one-shot -> busy for exactly 22 cycles, then one `o_done`; a start during busy is ignored (no `o_start_ack`).
- Retrigger mode, A=8, second start at busy cycle 5 with A=3 -> `o_count` reloads 2; busy for 5+3=8 cycles total; single `o_done`.
- Periodic mode, A=4 -> `o_done` every 4 cycles, `o_busy` never drops; abort at cycle 9 of the run -> busy 0 next cycle, no further `o_done`.
- Abort and start in the same cycle while idle -> no `o_start_ack`, busy stays 0. Reset asserted mid-run at count 3 -> all outputs 0 asynchronously.
- Macro on, P=2, A=3 -> busy for 9 cycles, `o_count` changes every 3 cycles, `o_done` at cycle N+10.
